// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, fetch-state encoding and IF/ID field layout for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    localparam int unsigned IF_ID_PC4_HI   = 63;
    localparam int unsigned IF_ID_PC4_LO   = 32;
    localparam int unsigned IF_ID_INSTR_HI = 31;
    localparam int unsigned IF_ID_INSTR_LO = 0;

    localparam logic [63:0] IF_ID_NOP = {32'h0000_0000, NOP_INSTR};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Bit 31 is the kernel-mode flag; sequential fetch never carries into it.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Redirect, instruction-memory and IF/ID signals of the fetch stage, bundled for its neighbours.
interface if_fetch_stage_if;

    logic        bubble;
    logic        PCSrcJ;
    logic        PCSrcJR;
    logic [31:0] jump_address;
    logic [31:0] jr_address;
    logic        IRQ_BACKUP;
    logic        exception;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [63:0] IF_ID;
    logic        IF_ID_valid;

    modport master (
        input  bubble, PCSrcJ, PCSrcJR, jump_address, jr_address, IRQ_BACKUP, exception,
        input  branch_taken, branch_address, imem_rdata, imem_valid,
        output imem_req, imem_addr, IF_ID, IF_ID_valid
    );

    modport slave (
        output bubble, PCSrcJ, PCSrcJR, jump_address, jr_address, IRQ_BACKUP, exception,
        output branch_taken, branch_address, imem_rdata, imem_valid,
        input  imem_req, imem_addr, IF_ID, IF_ID_valid
    );

endinterface

// File: rtl/if_fetch_stage_next_pc.sv
// Next-PC priority mux: decides whether any redirect is active and which target wins.
module if_next_pc
    import if_fetch_stage_pkg::*;
(
    input  logic        i_bubble,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_address,
    input  logic        i_exception,
    input  logic        i_irq_backup,
    input  logic        i_pcsrc_jr,
    input  logic [31:0] i_jr_address,
    input  logic        i_pcsrc_j,
    input  logic [31:0] i_jump_address,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    logic w_id_redir;

    // Decode operands are stale during a stall, so its redirects are masked; execute's are not.
    assign w_id_redir = ~i_bubble & (i_exception | i_irq_backup | i_pcsrc_jr | i_pcsrc_j);
    assign o_redirect = i_branch_taken | w_id_redir;

    always_comb begin
        o_target = i_jump_address;
        if (i_branch_taken) begin
            o_target = i_branch_address;
        end else if (i_exception) begin
            o_target = EXC_VECTOR;
        end else if (i_irq_backup) begin
            o_target = IRQ_VECTOR;
        end else if (i_pcsrc_jr) begin
            o_target = i_jr_address;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake and the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    if_fetch_stage_if.master bus
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_tgt, w_tgt_nxt;
    logic [31:0]  r_hold, w_hold_nxt;
    logic [63:0]  r_if_id, w_if_id_nxt;
    logic         r_if_id_v, w_if_id_v_nxt;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_imem_req;

    if_next_pc u_next_pc (
        .i_bubble         (bus.bubble),
        .i_branch_taken   (bus.branch_taken),
        .i_branch_address (bus.branch_address),
        .i_exception      (bus.exception),
        .i_irq_backup     (bus.IRQ_BACKUP),
        .i_pcsrc_jr       (bus.PCSrcJR),
        .i_jr_address     (bus.jr_address),
        .i_pcsrc_j        (bus.PCSrcJ),
        .i_jump_address   (bus.jump_address),
        .o_redirect       (w_redirect),
        .o_target         (w_target)
    );

    assign w_pc_plus4 = pc_plus4(r_pc);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_tgt_nxt     = r_tgt;
        w_hold_nxt    = r_hold;
        w_if_id_nxt   = r_if_id;
        w_if_id_v_nxt = r_if_id_v;
        w_imem_req    = 1'b1;

        unique case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    w_if_id_nxt   = IF_ID_NOP;
                    w_if_id_v_nxt = 1'b0;
                    if (bus.imem_valid) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_tgt_nxt   = w_target;
                        w_state_nxt = DRAIN;
                    end
                end else if (bus.imem_valid) begin
                    if (!bus.bubble) begin
                        w_if_id_nxt   = {w_pc_plus4, bus.imem_rdata};
                        w_if_id_v_nxt = 1'b1;
                        w_pc_nxt      = w_pc_plus4;
                    end else begin
                        w_hold_nxt  = bus.imem_rdata;
                        w_state_nxt = HOLD;
                    end
                end else if (!bus.bubble) begin
                    w_if_id_nxt   = IF_ID_NOP;
                    w_if_id_v_nxt = 1'b0;
                end
            end
            HOLD: begin
                w_imem_req = 1'b0;
                if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_if_id_nxt   = IF_ID_NOP;
                    w_if_id_v_nxt = 1'b0;
                    w_state_nxt   = FETCH;
                end else if (!bus.bubble) begin
                    w_if_id_nxt   = {w_pc_plus4, r_hold};
                    w_if_id_v_nxt = 1'b1;
                    w_pc_nxt      = w_pc_plus4;
                    w_state_nxt   = FETCH;
                end
            end
            DRAIN: begin
                // Keep presenting the old address until its response arrives; newest target wins.
                if (w_redirect) begin
                    w_tgt_nxt = w_target;
                end
                if (bus.imem_valid) begin
                    w_pc_nxt    = w_redirect ? w_target : r_tgt;
                    w_state_nxt = FETCH;
                end
                if (!bus.bubble || bus.branch_taken) begin
                    w_if_id_nxt   = IF_ID_NOP;
                    w_if_id_v_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_VECTOR;
            r_tgt     <= 32'h0000_0000;
            r_hold    <= NOP_INSTR;
            r_if_id   <= IF_ID_NOP;
            r_if_id_v <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_tgt     <= w_tgt_nxt;
            r_hold    <= w_hold_nxt;
            r_if_id   <= w_if_id_nxt;
            r_if_id_v <= w_if_id_v_nxt;
        end
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.IF_ID       = r_if_id;
    assign bus.IF_ID_valid = r_if_id_v;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage with a variable-latency memory and a queue-based fetch model.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    if_fetch_stage_if fif ();

    if_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus for the coming cycle
    logic        s_reset, s_bubble, s_j, s_jr, s_irq, s_exc, s_bt;
    logic [31:0] s_jaddr, s_jraddr, s_baddr;

    // Memory model
    bit          mem_busy;
    logic [31:0] mem_addr;
    int unsigned mem_wait, lat_min, lat_max;
    logic        mem_valid;

    // Reference model: expected fetch PC, IF/ID contents, parked word and pending redirect
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_v;
    logic [31:0] m_holdq[$];
    logic [31:0] m_redirq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h7FFF_FFFC;
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    task automatic clr_stim();
        s_reset = 0; s_bubble = 0; s_j = 0; s_jr = 0; s_irq = 0; s_exc = 0; s_bt = 0;
        s_jaddr = 32'h0040_0200; s_jraddr = 32'h0040_0300; s_baddr = 32'h0040_0400;
    endtask

    task automatic rand_stim();
        s_reset  = ($urandom_range(0, 199) == 0);
        s_bubble = ($urandom_range(0, 3) == 0);
        s_j      = ($urandom_range(0, 14) == 0);
        s_jr     = ($urandom_range(0, 14) == 0);
        s_irq    = ($urandom_range(0, 24) == 0);
        s_exc    = ($urandom_range(0, 24) == 0);
        s_bt     = ($urandom_range(0, 14) == 0);
        s_jaddr  = pick_addr();
        s_jraddr = pick_addr();
        s_baddr  = pick_addr();
    endtask

    task automatic flush_model();
        m_pc4 = 32'h0; m_instr = 32'h0; m_v = 1'b0;
    endtask

    task automatic model_step();
        logic        redirect;
        logic [31:0] tgt;
        logic [31:0] w;
        if (s_reset) begin
            m_pc = 32'h8000_0000;
            flush_model();
            m_holdq.delete();
            m_redirq.delete();
            return;
        end
        redirect = s_bt || (!s_bubble && (s_exc || s_irq || s_jr || s_j));
        if (s_bt)       tgt = s_baddr;
        else if (s_exc) tgt = 32'h8000_0008;
        else if (s_irq) tgt = 32'h8000_0004;
        else if (s_jr)  tgt = s_jraddr;
        else            tgt = s_jaddr;

        if (m_holdq.size() != 0) begin
            if (redirect) begin
                m_holdq.delete();
                m_pc = tgt;
                flush_model();
            end else if (!s_bubble) begin
                w = m_holdq.pop_front();
                m_pc4 = inc4(m_pc); m_instr = w; m_v = 1'b1;
                m_pc = inc4(m_pc);
            end
        end else if (m_redirq.size() != 0) begin
            if (redirect) m_redirq[0] = tgt;
            if (!(s_bubble && !s_bt)) flush_model();
            if (mem_valid) m_pc = m_redirq.pop_front();
        end else begin
            if (redirect) begin
                flush_model();
                if (mem_valid) m_pc = tgt;
                else m_redirq.push_back(tgt);
            end else if (mem_valid) begin
                if (!s_bubble) begin
                    m_pc4 = inc4(m_pc); m_instr = fif.imem_rdata; m_v = 1'b1;
                    m_pc = inc4(m_pc);
                end else begin
                    m_holdq.push_back(fif.imem_rdata);
                end
            end else if (!s_bubble) begin
                flush_model();
            end
        end
    endtask

    task automatic step();
        mem_valid = 1'b0;
        if (s_reset) begin
            mem_busy = 0;
        end else if (fif.imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_addr = fif.imem_addr;
                mem_wait = $urandom_range(lat_min, lat_max);
            end
            mem_valid = (mem_wait == 0);
        end
        reset              = s_reset;
        fif.bubble         = s_bubble;
        fif.PCSrcJ         = s_j;
        fif.PCSrcJR        = s_jr;
        fif.jump_address   = s_jaddr;
        fif.jr_address     = s_jraddr;
        fif.IRQ_BACKUP     = s_irq;
        fif.exception      = s_exc;
        fif.branch_taken   = s_bt;
        fif.branch_address = s_baddr;
        fif.imem_valid     = mem_valid;
        fif.imem_rdata     = word_for(mem_addr);
        model_step();
        @(posedge clk);
        if (mem_valid) mem_busy = 0;
        else if (mem_busy) mem_wait--;
        #1;
        chk("imem_req", {63'h0, fif.imem_req}, {63'h0, m_holdq.size() == 0});
        if (m_holdq.size() == 0) chk("imem_addr", {32'h0, fif.imem_addr}, {32'h0, m_pc});
        chk("if_id", fif.IF_ID, {m_pc4, m_instr});
        chk("if_id_valid", {63'h0, fif.IF_ID_valid}, {63'h0, m_v});
    endtask

    initial begin
        clr_stim();
        mem_busy = 0; mem_addr = 32'h0; mem_wait = 0; lat_min = 0; lat_max = 0;
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_v = 1'b0;
        reset = 1'b1;
        fif.imem_valid = 1'b0;
        fif.imem_rdata = 32'h0;
        s_reset = 1;
        repeat (2) step();
        s_reset = 0;
        chk("rst_addr", {32'h0, fif.imem_addr}, 64'h8000_0000);
        chk("rst_if_id", fif.IF_ID, 64'h0);
        chk("rst_valid", {63'h0, fif.IF_ID_valid}, 64'h0);

        // Zero-wait sequential fetch
        step();
        chk("zw_pc4_0", {32'h0, fif.IF_ID[63:32]}, 64'h8000_0004);
        chk("zw_instr_0", {32'h0, fif.IF_ID[31:0]}, {32'h0, word_for(32'h8000_0000)});
        step();
        chk("zw_pc4_1", {32'h0, fif.IF_ID[63:32]}, 64'h8000_0008);
        chk("zw_addr_2", {32'h0, fif.imem_addr}, 64'h8000_0008);
        chk("zw_valid_1", {63'h0, fif.IF_ID_valid}, 64'h1);

        // Taken branch outranks exception
        s_bt = 1; s_baddr = 32'h0040_0040; s_exc = 1;
        step();
        clr_stim();
        chk("bt_over_exc", {32'h0, fif.imem_addr}, 64'h0040_0040);

        s_irq = 1;
        step();
        clr_stim();
        chk("irq_vector", {32'h0, fif.imem_addr}, 64'h8000_0004);

        // Stall with a word arriving: parked, then released with PC+4
        s_bubble = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req", {63'h0, fif.imem_req}, 64'h0);
        end
        s_bubble = 0;
        step();
        chk("hold_pc4", {32'h0, fif.IF_ID[63:32]}, 64'h8000_0008);
        chk("hold_instr", {32'h0, fif.IF_ID[31:0]}, {32'h0, word_for(32'h8000_0004)});

        // Reset while parked
        s_bubble = 1;
        step();
        s_reset = 1;
        step();
        clr_stim();
        chk("hold_reset_addr", {32'h0, fif.imem_addr}, 64'h8000_0000);
        chk("hold_reset_req", {63'h0, fif.imem_req}, 64'h1);

        // jr masked by stall, honoured once the stall clears
        s_bubble = 1; s_jr = 1; s_jraddr = 32'h0040_0100;
        step();
        s_bubble = 0;
        step();
        clr_stim();
        chk("jr_after_bubble", {32'h0, fif.imem_addr}, 64'h0040_0100);

        // Branch while a 2-cycle fetch is outstanding
        lat_min = 2; lat_max = 2;
        step();
        s_bt = 1; s_baddr = 32'h0040_0040;
        step();
        clr_stim();
        chk("drain_addr_held", {32'h0, fif.imem_addr}, 64'h0040_0100);
        step();
        chk("drain_target", {32'h0, fif.imem_addr}, 64'h0040_0040);
        chk("drain_nop", {63'h0, fif.IF_ID_valid}, 64'h0);

        lat_min = 0; lat_max = 3;
        repeat (3000) begin
            rand_stim();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
